// File: rtl/m2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m2_pkg
// Purpose  : Shared types and constants for the Milestone 2 block mover:
//            FSM state encoding, command encodings, SRAM segment bases,
//            index pipe entry and the 8-bit pixel clip helper.
// Revision : 1.0 - initial release
// ============================================================================
package m2_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_F_ISSUE = 3'd1,
        S_F_DRAIN = 3'd2,
        S_W_RUN   = 3'd3,
        S_W_FLUSH = 3'd4,
        S_DONE    = 3'd5
    } m2_mover_state_type;

    // Command encodings
    localparam logic       MODE_FETCH = 1'b0;
    localparam logic       MODE_WRITE = 1'b1;
    localparam logic [1:0] SEG_Y      = 2'd0;
    localparam logic [1:0] SEG_U      = 2'd1;
    localparam logic [1:0] SEG_V      = 2'd2;

    // Segment bases (word addresses)
    localparam int unsigned PRE_BASE = 76800;
    localparam int unsigned YUV_BASE = 0;
    localparam logic [17:0] PRE_Y = 18'(PRE_BASE);
    localparam logic [17:0] PRE_U = 18'(PRE_BASE + 76800);
    localparam logic [17:0] PRE_V = 18'(PRE_BASE + 115200);
    localparam logic [17:0] YUV_Y = 18'(YUV_BASE);
    localparam logic [17:0] YUV_U = 18'(YUV_BASE + 38400);
    localparam logic [17:0] YUV_V = 18'(YUV_BASE + 57600);

    // Legal block coordinate limits
    localparam logic [5:0] BCOL_MAX_Y  = 6'd39;
    localparam logic [5:0] BCOL_MAX_UV = 6'd19;
    localparam logic [4:0] BROW_MAX    = 5'd29;

    // One stage of the delayed index pipe
    typedef struct packed {
        logic       vld;
        logic [5:0] idx;
    } m2_pipe_type;

    // Saturate a signed IDCT result into an unsigned 8-bit pixel
    function automatic logic [7:0] clip8(input logic signed [31:0] v);
        if (v < 32'sd0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/m2_block_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : m2_block_mover_if
// Purpose  : Command, SRAM and DP-RAM signals of the block mover. The mover
//            is the master; the command source / memories form the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface m2_block_mover_if;
    import m2_pkg::*;

    logic        start;
    logic        mode;
    logic [1:0]  seg;
    logic [5:0]  bcol;
    logic [4:0]  brow;
    logic        busy;
    logic        done;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_write_data;
    logic [15:0] SRAM_read_data;
    logic [6:0]  dp_address;
    logic        dp_wren;
    logic [31:0] dp_write_data;
    logic [31:0] dp_read_data;

    modport master (
        input  start, mode, seg, bcol, brow, SRAM_read_data, dp_read_data,
        output busy, done, SRAM_address, SRAM_we_n, SRAM_write_data,
               dp_address, dp_wren, dp_write_data
    );

    modport slave (
        output start, mode, seg, bcol, brow, SRAM_read_data, dp_read_data,
        input  busy, done, SRAM_address, SRAM_we_n, SRAM_write_data,
               dp_address, dp_wren, dp_write_data
    );
endinterface
`default_nettype wire

// File: rtl/m2_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : m2_addr_gen
// Purpose  : Combinational SRAM word address for element (r,c) of block
//            (bcol,brow) in the chosen segment. FETCH addresses the pre-IDCT
//            area (1 coeff/word), WRITE the YUV area (2 pixels/word).
// Revision : 1.0 - initial release
// ============================================================================
module m2_addr_gen
    import m2_pkg::*;
(
    input  wire        mode,
    input  wire  [1:0] seg,
    input  wire  [5:0] bcol,
    input  wire  [4:0] brow,
    input  wire  [2:0] r,
    input  wire  [2:0] c,
    output logic [17:0] addr
);

    logic [17:0] w_row;
    logic [17:0] w_row_off;
    logic [17:0] w_col;
    logic [17:0] w_base;

    // Base + row*W + column; W is 320/160/80, built from two shifts
    always_comb begin
        w_row     = {10'd0, brow, r};
        w_base    = '0;
        w_row_off = '0;
        w_col     = '0;
        if (mode == MODE_FETCH) begin
            w_col = {9'd0, bcol, c};
            case (seg)
                SEG_Y: begin
                    w_base    = PRE_Y;
                    w_row_off = (w_row << 8) + (w_row << 6);
                end
                SEG_U: begin
                    w_base    = PRE_U;
                    w_row_off = (w_row << 7) + (w_row << 5);
                end
                default: begin
                    w_base    = PRE_V;
                    w_row_off = (w_row << 7) + (w_row << 5);
                end
            endcase
        end else begin
            w_col = {10'd0, bcol, c[2:1]};
            case (seg)
                SEG_Y: begin
                    w_base    = YUV_Y;
                    w_row_off = (w_row << 7) + (w_row << 5);
                end
                SEG_U: begin
                    w_base    = YUV_U;
                    w_row_off = (w_row << 6) + (w_row << 4);
                end
                default: begin
                    w_base    = YUV_V;
                    w_row_off = (w_row << 6) + (w_row << 4);
                end
            endcase
        end
        addr = w_base + w_row_off + w_col;
    end

endmodule
`default_nettype wire

// File: rtl/m2_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : m2_block_mover
// Purpose  : Moves 8x8 blocks between SRAM and the Milestone 2 DP-RAM.
//            FETCH copies 64 coefficients SRAM -> DP-RAM; WRITE clips 64
//            IDCT results, packs pixel pairs and stores them to Y/U/V.
// Revision : 1.0 - initial release
// ============================================================================
module m2_block_mover
    import m2_pkg::*;
#(
    parameter int SRAM_RD_LAT = 3
) (
    input  wire                CLOCK_50_I,
    input  wire                resetn,
    m2_block_mover_if.master   bus
);

    localparam logic [5:0] c_last_idx   = 6'd63;
    localparam logic [5:0] c_drain_last = 6'(SRAM_RD_LAT - 1);

    m2_mover_state_type r_state;
    m2_mover_state_type w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic        r_mode;
    logic [1:0]  r_seg;
    logic [5:0]  r_bcol;
    logic [4:0]  r_brow;
    m2_pipe_type r_pipe [SRAM_RD_LAT];
    logic [7:0]  r_even;

    logic        w_legal;
    logic        w_issue;
    logic        w_fwr;
    logic        w_pix_vld;
    logic        w_swr;
    logic [7:0]  w_pix;
    logic [5:0]  w_ag_idx;
    logic [17:0] w_ag_addr;

    assign w_legal = (bus.seg != 2'd3) && (bus.brow <= BROW_MAX) &&
                     (bus.bcol <= ((bus.seg == SEG_Y) ? BCOL_MAX_Y : BCOL_MAX_UV));
    assign w_issue   = (r_state == S_F_ISSUE) || (r_state == S_W_RUN);
    // FETCH: the read issued SRAM_RD_LAT cycles ago is landing now
    assign w_fwr     = r_pipe[SRAM_RD_LAT-1].vld && (r_mode == MODE_FETCH) &&
                       ((r_state == S_F_ISSUE) || (r_state == S_F_DRAIN));
    // WRITE: DP-RAM data for last cycle's address is on dp_read_data
    assign w_pix_vld = r_pipe[0].vld && (r_mode == MODE_WRITE) &&
                       ((r_state == S_W_RUN) || (r_state == S_W_FLUSH));
    assign w_swr     = w_pix_vld && r_pipe[0].idx[0];
    assign w_pix     = clip8(bus.dp_read_data);
    assign w_ag_idx  = (r_state == S_F_ISSUE) ? r_cnt : r_pipe[0].idx;

    m2_addr_gen u_addr_gen (
        .mode (r_mode),
        .seg  (r_seg),
        .bcol (r_bcol),
        .brow (r_brow),
        .r    (w_ag_idx[5:3]),
        .c    (w_ag_idx[2:0]),
        .addr (w_ag_addr)
    );

    // State and element counter; reset forces S_IDLE even mid-block
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and all bus outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        bus.busy            = 1'b0;
        bus.done            = 1'b0;
        bus.SRAM_address    = '0;
        bus.SRAM_we_n       = 1'b1;
        bus.SRAM_write_data = '0;
        bus.dp_address      = '0;
        bus.dp_wren         = 1'b0;
        bus.dp_write_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cnt_nxt = '0;
                    if (!w_legal)
                        w_state_nxt = S_DONE;
                    else if (bus.mode == MODE_WRITE)
                        w_state_nxt = S_W_RUN;
                    else
                        w_state_nxt = S_F_ISSUE;
                end
            end
            S_F_ISSUE: begin
                w_cnt_nxt = r_cnt + 6'd1;
                if (r_cnt == c_last_idx) begin
                    w_state_nxt = S_F_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            S_F_DRAIN: begin
                w_cnt_nxt = r_cnt + 6'd1;
                if (r_cnt == c_drain_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_W_RUN: begin
                w_cnt_nxt = r_cnt + 6'd1;
                if (r_cnt == c_last_idx) begin
                    w_state_nxt = S_W_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            S_W_FLUSH: w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        bus.busy = (r_state == S_F_ISSUE) || (r_state == S_F_DRAIN) ||
                   (r_state == S_W_RUN)   || (r_state == S_W_FLUSH);
        bus.done = (r_state == S_DONE);

        if (r_state == S_F_ISSUE)
            bus.SRAM_address = w_ag_addr;
        else if (w_swr) begin
            bus.SRAM_address    = w_ag_addr;
            bus.SRAM_we_n       = 1'b0;
            bus.SRAM_write_data = {r_even, w_pix};
        end

        if (r_state == S_W_RUN)
            bus.dp_address = {1'b0, r_cnt};
        else if (w_fwr) begin
            bus.dp_address    = {1'b0, r_pipe[SRAM_RD_LAT-1].idx};
            bus.dp_wren       = 1'b1;
            bus.dp_write_data = {{16{bus.SRAM_read_data[15]}}, bus.SRAM_read_data};
        end
    end

    // Latch the command when start is accepted
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_mode <= 1'b0;
            r_seg  <= '0;
            r_bcol <= '0;
            r_brow <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_mode <= bus.mode;
            r_seg  <= bus.seg;
            r_bcol <= bus.bcol;
            r_brow <= bus.brow;
        end
    end

    // Delayed index pipe: remembers which element each access belonged to
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SRAM_RD_LAT; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {w_issue, r_cnt};
            for (int i = 1; i < SRAM_RD_LAT; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Hold the even-column pixel until its odd partner arrives
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn)
            r_even <= '0;
        else if (w_pix_vld && !r_pipe[0].idx[0])
            r_even <= w_pix;
    end

endmodule
`default_nettype wire

// File: tb/tb_m2_block_mover.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_m2_block_mover
// Purpose  : Directed self-checking bench for m2_block_mover with a 3-cycle
//            SRAM read model and a 1-cycle DP-RAM read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m2_block_mover;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    m2_block_mover_if bus();

    m2_block_mover #(.SRAM_RD_LAT(3)) dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory models
    logic [17:0] a1 = '0, a2 = '0, a3 = '0;
    logic [31:0] dp_rd_q = '0;
    logic [31:0] dpmem [64];

    always @(posedge clk) begin
        a1      <= bus.SRAM_address;
        a2      <= a1;
        a3      <= a2;
        dp_rd_q <= dpmem[bus.dp_address[5:0]];
    end
    assign bus.SRAM_read_data = (a3 == 18'd76808) ? 16'hFFFE : a3[15:0];
    assign bus.dp_read_data   = dp_rd_q;

    // Per-run observations (cycle 1 = first cycle after the accepting edge)
    int          done_cyc, busy_first, busy_last, busy_cnt, dpw_cnt, wr_cnt, addr_chg;
    logic [17:0] addr_log [200];
    logic [31:0] cap [64];
    logic [17:0] wr_addr [32];
    logic [15:0] wr_data [32];
    int          wr_cyc [32];

    task automatic run_cmd(input logic m, input logic [1:0] s, input logic [5:0] bc,
                           input logic [4:0] br, input int glitch, input int rst_at);
        done_cyc = -1; busy_first = -1; busy_last = -1;
        busy_cnt = 0; dpw_cnt = 0; wr_cnt = 0; addr_chg = 0;
        for (int i = 0; i < 64; i++) cap[i] = '0;
        for (int i = 0; i < 200; i++) addr_log[i] = '0;
        @(posedge clk); #1;
        bus.mode = m; bus.seg = s; bus.bcol = bc; bus.brow = br; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            addr_log[n] = bus.SRAM_address;
            if (bus.SRAM_address != 18'd0) addr_chg++;
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (bus.dp_wren) begin
                dpw_cnt++;
                cap[bus.dp_address[5:0]] = bus.dp_write_data;
            end
            if (!bus.SRAM_we_n) begin
                if (wr_cnt < 32) begin
                    wr_addr[wr_cnt] = bus.SRAM_address;
                    wr_data[wr_cnt] = bus.SRAM_write_data;
                    wr_cyc[wr_cnt]  = n;
                end
                wr_cnt++;
            end
            if (n == glitch) begin
                bus.start = 1'b1; bus.mode = 1'b1; bus.seg = 2'd2; bus.bcol = 6'd5; bus.brow = 5'd3;
            end
            if (n == glitch + 1) bus.start = 1'b0;
            if (n == rst_at) begin
                resetn = 1'b0;
                #1;
                check("rst_mid_we_n",  32'(bus.SRAM_we_n), 1);
                check("rst_mid_dp_wr", 32'(bus.dp_wren),   0);
                check("rst_mid_busy",  32'(bus.busy),      0);
                break;
            end
            if (bus.done) begin
                done_cyc = n;
                break;
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.seg = 2'd0; bus.bcol = 6'd0; bus.brow = 5'd0;
        for (int i = 0; i < 64; i++) dpmem[i] = 32'(i);
        dpmem[0] = 32'hFFFF_FFFB;   // -5  -> 0x00
        dpmem[1] = 32'd300;         // 300 -> 0xFF
        dpmem[2] = 32'h12;
        dpmem[3] = 32'h34;
        dpmem[4] = 32'd256;         // -> 0xFF
        dpmem[5] = 32'd255;         // -> 0xFF
        dpmem[6] = 32'd0;
        dpmem[7] = 32'hFFFF_FFFF;   // -1  -> 0x00

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(bus.busy),         0);
        check("rst_done",    32'(bus.done),         0);
        check("rst_we_n",    32'(bus.SRAM_we_n),    1);
        check("rst_dp_wren", 32'(bus.dp_wren),      0);
        check("rst_addr",    32'(bus.SRAM_address), 0);
        check("rst_dp_addr", 32'(bus.dp_address),   0);
        resetn = 1'b1;
        @(negedge clk);

        // FETCH Y bcol=1 brow=0
        run_cmd(1'b0, 2'd0, 6'd1, 5'd0, 0, 0);
        check("fy_addr_first", 32'(addr_log[1]),  76808);
        check("fy_addr_r1c0",  32'(addr_log[9]),  77128);
        check("fy_addr_last",  32'(addr_log[64]), 79055);
        check("fy_dp0",        cap[0],  32'hFFFF_FFFE);
        check("fy_dp9",        cap[9],  32'h0000_2D49);
        check("fy_dp63",       cap[63], 32'h0000_34CF);
        check("fy_done_cyc",   32'(done_cyc),   68);
        check("fy_busy_first", 32'(busy_first), 1);
        check("fy_busy_last",  32'(busy_last),  67);
        check("fy_busy_cnt",   32'(busy_cnt),   67);
        check("fy_dp_wren",    32'(dpw_cnt),    64);
        check("fy_sram_wr",    32'(wr_cnt),     0);

        // FETCH V at the last legal block
        run_cmd(1'b0, 2'd2, 6'd19, 5'd29, 0, 0);
        check("fv_addr_first", 32'(addr_log[1]),  229272);
        check("fv_addr_last",  32'(addr_log[64]), 230399);
        check("fv_done_cyc",   32'(done_cyc),     68);

        // WRITE U bcol=2 brow=1
        run_cmd(1'b1, 2'd1, 6'd2, 5'd1, 0, 0);
        check("wu_wr_cnt",    32'(wr_cnt),      32);
        check("wu_first_cyc", 32'(wr_cyc[0]),   3);
        check("wu_last_cyc",  32'(wr_cyc[31]),  65);
        check("wu_done_cyc",  32'(done_cyc),    66);
        check("wu_busy_cnt",  32'(busy_cnt),    65);
        check("wu_dp_wren",   32'(dpw_cnt),     0);
        check("wu_addr0",     32'(wr_addr[0]),  39048);
        check("wu_addr1",     32'(wr_addr[1]),  39049);
        check("wu_addr4",     32'(wr_addr[4]),  39128);
        check("wu_addr31",    32'(wr_addr[31]), 39611);
        check("wu_clip01",    32'(wr_data[0]),  32'h00FF);
        check("wu_pack23",    32'(wr_data[1]),  32'h1234);
        check("wu_clip45",    32'(wr_data[2]),  32'hFFFF);
        check("wu_clip67",    32'(wr_data[3]),  32'h0000);
        check("wu_data4",     32'(wr_data[4]),  32'h0809);
        check("wu_data31",    32'(wr_data[31]), 32'h3E3F);

        // Illegal commands: seg=3, Y bcol=40, V brow=30
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       run_cmd(1'b0, 2'd3, 6'd0,  5'd0,  0, 0);
                1:       run_cmd(1'b1, 2'd0, 6'd40, 5'd0,  0, 0);
                default: run_cmd(1'b0, 2'd2, 6'd0,  5'd30, 0, 0);
            endcase
            check($sformatf("ill%0d_done_cyc", k), 32'(done_cyc), 1);
            check($sformatf("ill%0d_sram_wr",  k), 32'(wr_cnt),   0);
            check($sformatf("ill%0d_addr_chg", k), 32'(addr_chg), 0);
            check($sformatf("ill%0d_dp_wren",  k), 32'(dpw_cnt),  0);
            check($sformatf("ill%0d_busy",     k), 32'(busy_cnt), 0);
        end

        // Start pulse plus command changes while busy are ignored
        run_cmd(1'b0, 2'd0, 6'd1, 5'd0, 10, 0);
        check("gl_addr_c30",  32'(addr_log[30]), 77773);
        check("gl_done_cyc",  32'(done_cyc),     68);
        check("gl_sram_wr",   32'(wr_cnt),       0);
        busy_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.busy || bus.done) busy_cnt++;
        end
        check("gl_no_rerun",  32'(busy_cnt),     0);

        // Reset in the middle of a FETCH, then a clean block
        run_cmd(1'b0, 2'd0, 6'd1, 5'd0, 0, 30);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_cmd(1'b0, 2'd0, 6'd1, 5'd0, 0, 0);
        check("rr_done_cyc",  32'(done_cyc), 68);
        check("rr_dp_wren",   32'(dpw_cnt),  64);
        check("rr_dp0",       cap[0],        32'hFFFF_FFFE);
        check("rr_addr_first", 32'(addr_log[1]), 76808);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
